// File: rtl/pdp_exec_mem_responder.sv
// PDP-8 exec-unit memory responder: 4K x 12 main store, exec + fetch read ports,
// exec write port, reset-time preload, saturating counters and sticky error flags.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   ifu_rd_req/addr/data    fetch read, data valid the cycle after the request
//   exec_rd_req/addr/data   exec read, data valid the cycle after the request
//   exec_wr_req/addr/data   exec write, committed at the request edge
//   load_en/addr/data       preload write, honoured only while reset=1
//   rd_count, wr_count      saturating exec read / write counters
//   proto_err               sticky [0] rd+wr clash, [1] rd stuck, [2] out of range
module pdp_exec_mem_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 12,
    parameter int MEM_DEPTH   = 4096,
    parameter int CNT_WIDTH   = 16,
    parameter int STUCK_LIMIT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic [DATA_WIDTH-1:0] ifu_rd_data,
    input  logic                  exec_rd_req,
    input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
    output logic [DATA_WIDTH-1:0] exec_rd_data,
    input  logic                  exec_wr_req,
    input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
    input  logic [DATA_WIDTH-1:0] exec_wr_data,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  wr_count,
    output logic [2:0]            proto_err
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int SC_W  = $clog2(STUCK_LIMIT + 2);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [SC_W-1:0]     LIMIT_C = SC_W'(STUCK_LIMIT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_ACTIVE = 2'd1,
        RD_STUCK  = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    state_t                state_q, state_d;
    logic [SC_W-1:0]       stuck_cnt_q, stuck_cnt_d;
    logic [DATA_WIDTH-1:0] ifu_rd_data_q, ifu_rd_data_d;
    logic [DATA_WIDTH-1:0] exec_rd_data_q, exec_rd_data_d;
    logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;
    logic [CNT_WIDTH-1:0]  wr_count_q, wr_count_d;
    logic [2:0]            proto_err_q, proto_err_d;

    logic                  mem_we;
    logic [IDX_W-1:0]      mem_widx;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic                  ifu_in_rng;
    logic                  rd_in_rng;
    logic                  wr_in_rng;
    logic                  ld_in_rng;
    logic [SC_W-1:0]       stuck_inc;

    function automatic logic in_rng(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < DEPTH_C;
    endfunction

    function automatic logic [IDX_W-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'(a);
    endfunction

    assign ifu_in_rng = in_rng(ifu_rd_addr);
    assign rd_in_rng  = in_rng(exec_rd_addr);
    assign wr_in_rng  = in_rng(exec_wr_addr);
    assign ld_in_rng  = in_rng(load_addr);
    assign stuck_inc  = stuck_cnt_q + 1'b1;

    // Single write port: preload owns it during reset, exec writes otherwise.
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = idx(exec_wr_addr);
        mem_wdata = exec_wr_data;
        if (reset) begin
            mem_we    = load_en && ld_in_rng;
            mem_widx  = idx(load_addr);
            mem_wdata = load_data;
        end else begin
            mem_we = exec_wr_req && wr_in_rng;
        end
    end

    // The array update is a nonblocking write, so reads sampled at the
    // same edge see the pre-write word (read-before-write).
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    // Read responses and counters.
    always_comb begin
        ifu_rd_data_d  = ifu_rd_data_q;
        exec_rd_data_d = exec_rd_data_q;
        rd_count_d     = rd_count_q;
        wr_count_d     = wr_count_q;
        proto_err_d    = proto_err_q;

        if (ifu_rd_req) begin
            ifu_rd_data_d = ifu_in_rng ? mem[idx(ifu_rd_addr)] : '0;
            if (!ifu_in_rng) begin
                proto_err_d[2] = 1'b1;
            end
        end

        if (exec_rd_req) begin
            exec_rd_data_d = rd_in_rng ? mem[idx(exec_rd_addr)] : '0;
            if (rd_count_q != '1) begin
                rd_count_d = rd_count_q + 1'b1;
            end
            if (!rd_in_rng) begin
                proto_err_d[2] = 1'b1;
            end
        end

        if (exec_wr_req) begin
            if (wr_count_q != '1) begin
                wr_count_d = wr_count_q + 1'b1;
            end
            if (!wr_in_rng) begin
                proto_err_d[2] = 1'b1;
            end
        end

        if (exec_rd_req && exec_wr_req) begin
            proto_err_d[0] = 1'b1;
        end

        if (state_d == RD_STUCK && state_q != RD_STUCK) begin
            proto_err_d[1] = 1'b1;
        end
    end

    // Stuck-read watchdog: counts consecutive cycles with exec_rd_req high.
    always_comb begin
        state_d     = state_q;
        stuck_cnt_d = stuck_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (exec_rd_req) begin
                    stuck_cnt_d = SC_W'(1);
                    state_d     = (SC_W'(1) > LIMIT_C) ? RD_STUCK : RD_ACTIVE;
                end
            end
            RD_ACTIVE: begin
                if (!exec_rd_req) begin
                    stuck_cnt_d = '0;
                    state_d     = IDLE;
                end else if (stuck_inc > LIMIT_C) begin
                    state_d = RD_STUCK;
                end else begin
                    stuck_cnt_d = stuck_inc;
                end
            end
            RD_STUCK: begin
                if (!exec_rd_req) begin
                    stuck_cnt_d = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                stuck_cnt_d = '0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            stuck_cnt_q    <= '0;
            ifu_rd_data_q  <= '0;
            exec_rd_data_q <= '0;
            rd_count_q     <= '0;
            wr_count_q     <= '0;
            proto_err_q    <= '0;
        end else begin
            state_q        <= state_d;
            stuck_cnt_q    <= stuck_cnt_d;
            ifu_rd_data_q  <= ifu_rd_data_d;
            exec_rd_data_q <= exec_rd_data_d;
            rd_count_q     <= rd_count_d;
            wr_count_q     <= wr_count_d;
            proto_err_q    <= proto_err_d;
        end
    end

    assign ifu_rd_data  = ifu_rd_data_q;
    assign exec_rd_data = exec_rd_data_q;
    assign rd_count     = rd_count_q;
    assign wr_count     = wr_count_q;
    assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_pdp_exec_mem_responder.sv
// Directed bench for pdp_exec_mem_responder with a read-response scoreboard.
// Instance uses MEM_DEPTH=1024 so addresses >= 0o2000 are out of range.
module tb_pdp_exec_mem_responder;

    logic        clk;
    logic        reset;
    logic        ifu_rd_req;
    logic [11:0] ifu_rd_addr;
    logic [11:0] ifu_rd_data;
    logic        exec_rd_req;
    logic [11:0] exec_rd_addr;
    logic [11:0] exec_rd_data;
    logic        exec_wr_req;
    logic [11:0] exec_wr_addr;
    logic [11:0] exec_wr_data;
    logic        load_en;
    logic [11:0] load_addr;
    logic [11:0] load_data;
    logic [15:0] rd_count;
    logic [15:0] wr_count;
    logic [2:0]  proto_err;

    pdp_exec_mem_responder #(
        .ADDR_WIDTH (12),
        .DATA_WIDTH (12),
        .MEM_DEPTH  (1024),
        .CNT_WIDTH  (16),
        .STUCK_LIMIT(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ifu_rd_req  (ifu_rd_req),
        .ifu_rd_addr (ifu_rd_addr),
        .ifu_rd_data (ifu_rd_data),
        .exec_rd_req (exec_rd_req),
        .exec_rd_addr(exec_rd_addr),
        .exec_rd_data(exec_rd_data),
        .exec_wr_req (exec_wr_req),
        .exec_wr_addr(exec_wr_addr),
        .exec_wr_data(exec_wr_data),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .rd_count    (rd_count),
        .wr_count    (wr_count),
        .proto_err   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // bit 12 selects the ifu port, bits 11:0 hold the expected word
    logic [12:0] exp_q [$];
    string       tag_q [$];

    logic [15:0] exp_rd;
    logic [15:0] exp_wr;
    logic [2:0]  exp_err;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input bit is_ifu,
                        input logic [11:0] val);
        exp_q.push_back({is_ifu, val});
        tag_q.push_back(tag);
    endtask

    task automatic exec_rd(input string tag, input logic [11:0] a,
                           input logic [11:0] val);
        exec_rd_req  = 1'b1;
        exec_rd_addr = a;
        push(tag, 1'b0, val);
        if (exp_rd != 16'hFFFF) exp_rd++;
    endtask

    task automatic exec_wr(input logic [11:0] a, input logic [11:0] d);
        exec_wr_req  = 1'b1;
        exec_wr_addr = a;
        exec_wr_data = d;
        if (exp_wr != 16'hFFFF) exp_wr++;
    endtask

    task automatic ifu_rd(input string tag, input logic [11:0] a,
                          input logic [11:0] val);
        ifu_rd_req  = 1'b1;
        ifu_rd_addr = a;
        push(tag, 1'b1, val);
    endtask

    task automatic idle();
        ifu_rd_req  = 1'b0;
        exec_rd_req = 1'b0;
        exec_wr_req = 1'b0;
        load_en     = 1'b0;
    endtask

    task automatic step();
        logic [12:0] e;
        string       t;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, e[12] ? ifu_rd_data : exec_rd_data, e[11:0]);
        end
    endtask

    task automatic status(input string tag);
        chk({tag, ".rd_count"}, rd_count, exp_rd);
        chk({tag, ".wr_count"}, wr_count, exp_wr);
        chk({tag, ".proto_err"}, proto_err, exp_err);
    endtask

    task automatic preload(input logic [11:0] a, input logic [11:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
    endtask

    initial begin
        reset        = 1'b1;
        ifu_rd_addr  = '0;
        exec_rd_addr = '0;
        exec_wr_addr = '0;
        exec_wr_data = '0;
        load_addr    = '0;
        load_data    = '0;
        idle();
        exp_rd  = '0;
        exp_wr  = '0;
        exp_err = '0;

        // preload under reset; 0o2000 is out of range and must be dropped
        preload(12'o0200, 12'o1234);
        chk("rst.exec_rd_data", exec_rd_data, 12'o0);
        chk("rst.ifu_rd_data", ifu_rd_data, 12'o0);
        status("rst");
        preload(12'o0400, 12'o0005);
        preload(12'o0500, 12'o0011);
        preload(12'o0600, 12'o4321);
        preload(12'o0000, 12'o0707);
        preload(12'o2000, 12'o7171);

        // preload strobe after reset is ignored without error
        reset     = 1'b0;
        load_en   = 1'b1;
        load_addr = 12'o0200;
        load_data = 12'o7070;
        step();
        status("ld_ign");
        idle();

        exec_rd("t1.rd200", 12'o0200, 12'o1234);
        step();
        status("t1");
        idle();
        step();
        chk("t1.hold", exec_rd_data, 12'o1234);

        exec_wr(12'o0300, 12'o7777);
        step();
        status("t2.wr");
        idle();
        exec_rd("t2.rd300", 12'o0300, 12'o7777);
        step();
        status("t2.rd");
        idle();
        step();

        // fetch read racing exec write to same address sees old data
        ifu_rd("t3.ifu_old", 12'o0400, 12'o0005);
        exec_wr(12'o0400, 12'o0006);
        step();
        idle();
        ifu_rd("t3.ifu_new", 12'o0400, 12'o0006);
        step();
        status("t3");
        idle();

        ifu_rd("t3b.ifu0", 12'o0000, 12'o0707);
        exec_rd("t3b.rd600", 12'o0600, 12'o4321);
        step();
        idle();
        step();

        // exec read + write clash
        exec_rd("t4.rd_old", 12'o0500, 12'o0011);
        exec_wr(12'o0500, 12'o0022);
        exp_err = 3'b001;
        step();
        status("t4");
        idle();
        step();
        exec_rd("t4.rd_new", 12'o0500, 12'o0022);
        step();
        idle();
        step();

        // two-cycle hold stays below the stuck limit
        exec_rd("t5a.r1", 12'o0200, 12'o1234);
        step();
        status("t5a.c1");
        exec_rd("t5a.r2", 12'o0300, 12'o7777);
        step();
        status("t5a.c2");
        idle();
        step();
        status("t5a.idle");

        // three-cycle hold trips the stuck flag on the third edge
        exec_rd("t5b.r1", 12'o0400, 12'o0006);
        step();
        status("t5b.c1");
        exec_rd("t5b.r2", 12'o0500, 12'o0022);
        step();
        status("t5b.c2");
        exec_rd("t5b.r3", 12'o0000, 12'o0707);
        exp_err = 3'b011;
        step();
        status("t5b.c3");
        idle();
        step();

        // out-of-range read, then out-of-range write must not alias to 0
        exec_rd("t6.rd_oor", 12'o2000, 12'o0000);
        exp_err = 3'b111;
        step();
        status("t6.rd");
        idle();
        step();
        exec_wr(12'o2000, 12'o7654);
        step();
        status("t6.wr");
        idle();
        exec_rd("t6.rd0", 12'o0000, 12'o0707);
        step();
        idle();
        step();

        // reset mid-access: response discarded, write not committed
        reset = 1'b1;
        exec_rd_req  = 1'b1;
        exec_rd_addr = 12'o0200;
        exec_wr_req  = 1'b1;
        exec_wr_addr = 12'o0600;
        exec_wr_data = 12'o5555;
        ifu_rd_req   = 1'b1;
        ifu_rd_addr  = 12'o0300;
        exp_rd  = '0;
        exp_wr  = '0;
        exp_err = '0;
        step();
        chk("rst2.exec_rd_data", exec_rd_data, 12'o0);
        chk("rst2.ifu_rd_data", ifu_rd_data, 12'o0);
        status("rst2");
        reset = 1'b0;
        idle();
        step();
        exec_rd("rst2.rd600", 12'o0600, 12'o4321);
        ifu_rd("rst2.ifu300", 12'o0300, 12'o7777);
        step();
        status("rst2.after");
        idle();
        step();

        // write counter saturation
        exec_wr_req  = 1'b1;
        exec_wr_addr = 12'o0100;
        for (int i = 0; i < 65540; i++) begin
            exec_wr_data = 12'(i);
            @(posedge clk);
            #1;
            if (exp_wr != 16'hFFFF) exp_wr++;
        end
        chk("sat.wr_count", wr_count, 16'hFFFF);
        idle();
        exec_rd("sat.rd100", 12'o0100, 12'(65539));
        step();
        status("sat");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pdp_exec_mem_responder.md
Name: pdp_exec_mem_responder

Overview:
Memory-side responder for the PDP-8 execution unit's memory interface. It owns the 4K x 12 main store and services two masters:
- exec read/write requests from the exec unit;
- instruction-fetch reads from the decoder.

Read data is returned with fixed one-cycle latency. It also provides a reset-time preload port, saturating access counters and sticky protocol-error flags for the unit and full-chip benches.

Parameters:
ADDR_WIDTH, 12, address width of both ports
DATA_WIDTH, 12, word width
MEM_DEPTH, 4096, implemented words; addresses >= MEM_DEPTH are out of range
CNT_WIDTH, 16, width of access counters
STUCK_LIMIT, 2, max consecutive cycles exec_rd_req may stay high before flagging

Ports:
clk  input  1  free-running clock
reset  input  1  synchronous, active-high reset
ifu_rd_req  input  1  instruction-fetch read request
ifu_rd_addr  input  ADDR_WIDTH  fetch address
ifu_rd_data  output  DATA_WIDTH  fetch data, valid cycle after request
exec_rd_req  input  1  exec read request
exec_rd_addr  input  ADDR_WIDTH  exec read address
exec_rd_data  output  DATA_WIDTH  exec read data, valid cycle after request
exec_wr_req  input  1  exec write request
exec_wr_addr  input  ADDR_WIDTH  exec write address
exec_wr_data  input  DATA_WIDTH  exec write data
load_en  input  1  preload write strobe, honoured only while reset=1
load_addr  input  ADDR_WIDTH  preload address
load_data  input  DATA_WIDTH  preload data
rd_count  output  CNT_WIDTH  exec reads serviced, saturating
wr_count  output  CNT_WIDTH  exec writes committed, saturating
proto_err  output  3  sticky: [0] exec rd+wr same cycle, [1] exec_rd_req stuck, [2] out-of-range access

Behaviour:
- Reset (sampled at posedge clk, reset=1):
  - ifu_rd_data, exec_rd_data, rd_count, wr_count, proto_err all go to 0; the stuck counter goes to 0; the FSM goes to IDLE.
  - The memory array is NOT cleared.
- Preload: load_en=1 with reset=1 writes load_data to load_addr at that edge. load_en with reset=0 is ignored (no error).
- Exec read: exec_rd_req=1 at edge N latches mem[exec_rd_addr] into exec_rd_data, visible during cycle N+1. exec_rd_data then holds until the next exec read response. rd_count increments.
- Ifu read: identical timing on ifu_rd_data. Fetch reads are independent of exec and not counted.
- Exec write: exec_wr_req=1 at edge N commits exec_wr_data to mem[exec_wr_addr] at edge N. wr_count increments.
- Read-during-write semantics:
  - Any read sampled in the same cycle as a write to the same address returns OLD data (read-before-write).
  - A read one cycle later returns the new data.
- exec_rd_req and exec_wr_req high in the same cycle:
  - the write is committed;
  - the read still returns pre-write data;
  - proto_err[0] is set.
- Out of range (address >= MEM_DEPTH):
  - reads return 0;
  - writes and preloads are dropped;
  - proto_err[2] is set (except for preloads);
  - counters still increment for exec accesses.
- Counters saturate at all-ones; they never wrap.
- Stuck-read FSM, states IDLE, RD_ACTIVE, RD_STUCK:
  - IDLE -> RD_ACTIVE on exec_rd_req=1, with the stuck counter set to 1.
  - In RD_ACTIVE: exec_rd_req=1 increments the counter; exec_rd_req=0 returns to IDLE and clears the counter.
  - When the counter would exceed STUCK_LIMIT, go to RD_STUCK and set proto_err[1].
  - RD_STUCK -> IDLE when exec_rd_req=0.
  - Back-to-back reads in every state are still serviced each cycle (pipelined), one response per request.
- proto_err bits clear only on reset.
- Reset asserted mid-access: the pending response is discarded and outputs go to 0 at that edge. A write sampled at the same edge as reset=1 is NOT committed; only load_en writes occur during reset.

Test Plan:
- Preload mem[0o200]=0o1234 under reset, release, exec_rd_req addr 0o200 at edge N -> exec_rd_data=0o1234 in cycle N+1; rd_count=1.
- Exec write 0o7777 to 0o300 at N, exec read 0o300 at N+1 -> data 0o7777 in cycle N+2; wr_count=1.
- Ifu read and exec write to 0o400 (old 0o0005, new 0o0006) in the same cycle -> ifu_rd_data=0o0005; an ifu read next cycle returns 0o0006.
- Simultaneous exec_rd_req/exec_wr_req to 0o500 (old 0o0011, new 0o0022) -> exec_rd_data=0o0011, mem=0o0022, proto_err=3'b001.
- exec_rd_req held 3 cycles with STUCK_LIMIT=2 -> three responses returned, proto_err[1]=1 after the third edge; a 2-cycle hold leaves proto_err[1]=0.
- MEM_DEPTH=1024, exec read of 0o2000 -> exec_rd_data=0, proto_err[2]=1; 65536+ writes -> wr_count stays 0xFFFF.
